unified_mem: RTL and testbench

- Unified instruction/data word memory for the multicycle MIPS core. It sits directly downstream of the core and consumes `addr`, `write_data` and `mem_write`; it returns `read_data`.
- After reset it zero-fills itself, then accepts a program image over a streaming load port, then enters run mode and services the core.
- Protocol violations by the core are reported through sticky error flags.

---
 rtl/unified_mem.sv | 78 +++++++
 tb/tb_unified_mem.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/unified_mem.sv
// unified_mem: unified instruction/data word memory that zero-fills after reset,
// accepts a streamed program image, then serves core reads/writes with sticky error flags.
module unified_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_write,
    input  logic [31:0]      addr,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    output logic             ready,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             err_misalign,
    output logic             err_range
);
    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx, widx, mem_addr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] mem_wdata;
    logic             in_range, aligned, idx_max, accept, run_wr, mem_we;

    assign widx      = addr[IDX_W+1:2];
    assign in_range  = addr[31:IDX_W+2] == '0;
    assign aligned   = addr[1:0] == 2'b00;
    assign idx_max   = idx == IDX_W'(DEPTH - 1);
    assign ready     = state == RUN;
    assign ld_ready  = state == LOAD;
    assign accept    = ld_ready && ld_valid;
    assign run_wr    = ready && mem_write;
    // One shared write port: clear, image load and core stores never overlap in time.
    assign mem_we    = state == CLEAR || accept || (run_wr && aligned && in_range);
    assign mem_addr  = ready ? widx : idx;
    assign mem_wdata = state == CLEAR ? '0 : ld_ready ? ld_data : write_data;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            CLEAR: begin
                idx_nx = idx + 1'b1;
                if (idx_max) state_nx = LOAD;
            end
            LOAD: if (accept) begin
                idx_nx = idx + 1'b1;
                if (ld_last || idx_max) state_nx = RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= CLEAR;
            idx          <= '0;
            read_data    <= '0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            read_data    <= (ready && in_range) ? mem[widx] : '0;
            err_misalign <= err_misalign | (run_wr && !aligned);
            err_range    <= err_range | (run_wr && !in_range);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
endmodule

// File: tb/tb_unified_mem.sv
// tb_unified_mem: checks clear timing, image load, run-mode access and error flags of unified_mem.
module tb_unified_mem;
    localparam int W = 32;
    localparam int D = 16;

    logic          clk = 1'b0, reset = 1'b0;
    logic          mem_write = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [31:0]   addr = '0;
    logic [W-1:0]  write_data = '0, ld_data = '0;
    logic [W-1:0]  read_data;
    logic          ready, ld_ready, err_misalign, err_range;

    int            total = 0, passed = 0;
    logic [W-1:0]  model [D];
    bit            m_mis, m_rng;

    typedef struct {
        logic [31:0] a;
        bit          we;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          mis;
        bit          rng;
    } vec_t;
    vec_t tbl [12];

    unified_mem #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .addr(addr),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .err_misalign(err_misalign), .err_range(err_range)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read_data"}, read_data, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_ld_ready"}, ld_ready, 0);
        check({tag, "_err_misalign"}, err_misalign, 0);
        check({tag, "_err_range"}, err_range, 0);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        {mem_write, ld_valid, ld_last} = '0;
        addr = '0; write_data = '0; ld_data = '0;
        #1;
        check_idle_outputs("reset");
        step;
        reset = 1'b1;
        m_mis = 0; m_rng = 0;
        for (int i = 0; i < D; i++) model[i] = '0;
    endtask

    // Zero-fill lasts exactly D cycles; writes and beats offered meanwhile must be ignored.
    task automatic wait_clear;
        ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF; mem_write = 1'b1; addr = 32'h4; write_data = 32'h1234;
        for (int c = 0; c < D; c++) begin
            check("clear_ld_ready", ld_ready, 0);
            check("clear_ready", ready, 0);
            check("clear_read_data", read_data, 0);
            step;
        end
        ld_valid = 1'b0; mem_write = 1'b0; addr = '0;
        check("load_ld_ready", ld_ready, 1);
        check("load_ready", ready, 0);
    endtask

    task automatic beat(input logic [W-1:0] d, input bit last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        step;
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // Reference: word memory, reads see pre-write contents, out-of-range reads give 0.
    task automatic run_cycle(input string name, input logic [31:0] a, input bit we, input logic [31:0] wd);
        logic [31:0] exp;
        bit ok_range, ok_align;
        ok_range = (a >> 6) == 0;
        ok_align = (a % 4) == 0;
        exp = ok_range ? model[(a / 4) % D] : 32'h0;
        if (we) begin
            if (!ok_align) m_mis = 1;
            if (!ok_range) m_rng = 1;
            if (ok_align && ok_range) model[(a / 4) % D] = wd;
        end
        addr = a; mem_write = we; write_data = wd;
        step;
        mem_write = 1'b0;
        check({name, "_read_data"}, read_data, exp);
        check({name, "_err_misalign"}, err_misalign, 32'(m_mis));
        check({name, "_err_range"}, err_range, 32'(m_rng));
    endtask

    initial begin
        tbl[0]  = '{32'h0,  0, 32'h0,        32'hA,        0, 0};
        tbl[1]  = '{32'h4,  0, 32'h0,        32'hB,        0, 0};
        tbl[2]  = '{32'h8,  0, 32'h0,        32'hC,        0, 0};
        tbl[3]  = '{32'hC,  0, 32'h0,        32'h0,        0, 0};
        tbl[4]  = '{32'h8,  1, 32'hDEADBEEF, 32'hC,        0, 0};
        tbl[5]  = '{32'h8,  0, 32'h0,        32'hDEADBEEF, 0, 0};
        tbl[6]  = '{32'h6,  1, 32'h12345678, 32'hB,        1, 0};
        tbl[7]  = '{32'h4,  0, 32'h0,        32'hB,        1, 0};
        tbl[8]  = '{32'h40, 1, 32'h55,       32'h0,        1, 1};
        tbl[9]  = '{32'h40, 0, 32'h0,        32'h0,        1, 1};
        tbl[10] = '{32'h0,  0, 32'h0,        32'hA,        1, 1};
        tbl[11] = '{32'h3,  0, 32'h0,        32'hA,        1, 1};

        // Clear timing, then a short image with an idle gap.
        do_reset;
        wait_clear;
        beat(32'hA, 0);
        beat(32'hB, 0);
        step;
        check("idle_ld_ready", ld_ready, 1);
        beat(32'hC, 1);
        check("run_ready", ready, 1);
        check("run_ld_ready", ld_ready, 0);
        for (int i = 0; i < 12; i++) begin
            addr = tbl[i].a; mem_write = tbl[i].we; write_data = tbl[i].wd;
            step;
            mem_write = 1'b0;
            check($sformatf("tbl%0d_read_data", i), read_data, tbl[i].rd);
            check($sformatf("tbl%0d_err_misalign", i), err_misalign, 32'(tbl[i].mis));
            check($sformatf("tbl%0d_err_range", i), err_range, 32'(tbl[i].rng));
        end

        // Overfull image: only D beats land, then RUN.
        do_reset;
        wait_clear;
        for (int b = 1; b <= 20; b++) begin
            check($sformatf("fill_ld_ready_%0d", b), ld_ready, 32'(b <= D));
            ld_valid = 1'b1; ld_data = 32'h100 + b;
            if (b <= D) model[b-1] = 32'h100 + b;
            step;
        end
        ld_valid = 1'b0;
        check("fill_ready", ready, 1);
        run_cycle("fill_last_word", 32'h3C, 0, 0);
        for (int i = 0; i < D; i++) run_cycle($sformatf("fill_word%0d", i), 32'(i * 4), 0, 0);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, D - 1)) << 2;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 1023)) << 6);
            run_cycle("rand", a, $urandom_range(0, 1) == 1, $urandom);
        end

        // Reset in the middle of a load aborts it and forces a fresh clear.
        do_reset;
        wait_clear;
        beat(32'h11, 0);
        beat(32'h22, 0);
        check("midload_ld_ready", ld_ready, 1);
        reset = 1'b0;
        #1;
        check_idle_outputs("midload_reset");
        step;
        reset = 1'b1;
        wait_clear;
        beat(32'h0, 1);
        check("reload_ready", ready, 1);
        run_cycle("reload_word0", 32'h0, 0, 0);
        run_cycle("reload_word1", 32'h4, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
